// File: rtl/alu_div_sequencer_pkg.sv
// Shared types and constants for the ALU-borrowing divide sequencer.
package alu_div_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_e;

    localparam logic [3:0] ALU_OP_COPY = 4'h0;
    localparam logic [3:0] ALU_OP_SUB  = 4'hB;

    // Bit positions in the ALU flags word
    localparam int FLAG_ZERO    = 0;
    localparam int FLAG_NEG     = 1;
    localparam int FLAG_CARRY   = 2;
    localparam int FLAG_OVF     = 3;
    localparam int FLAG_DIV_ERR = 4;

    // Two's-complement negation of a 16-bit word
    function automatic logic [15:0] neg16(input logic [15:0] v);
        return ~v + 16'd1;
    endfunction

endpackage

// File: rtl/alu_div_sign_fix.sv
// Signed-division helpers: operand magnitudes at accept time and the
// quotient/remainder sign correction applied in the FIXUP state.
module alu_div_sign_fix
    import alu_div_sequencer_pkg::*;
(
    input  logic        signed_i,
    input  logic [15:0] dividend_i,
    input  logic [15:0] divisor_i,
    output logic [15:0] dividend_mag_o,
    output logic [15:0] divisor_mag_o,
    output logic        quo_neg_o,
    output logic        rem_neg_o,
    input  logic        fix_quo_neg_i,
    input  logic        fix_rem_neg_i,
    input  logic [15:0] quotient_mag_i,
    input  logic [15:0] remainder_mag_i,
    output logic [15:0] quotient_o,
    output logic [15:0] remainder_o,
    output logic        ovf_o
);

    // Magnitude conversion and sign bookkeeping for an incoming request
    always_comb begin
        dividend_mag_o = (signed_i && dividend_i[15]) ? neg16(dividend_i) : dividend_i;
        divisor_mag_o  = (signed_i && divisor_i[15])  ? neg16(divisor_i)  : divisor_i;
        quo_neg_o      = signed_i & (dividend_i[15] ^ divisor_i[15]);
        rem_neg_o      = signed_i & dividend_i[15];
    end

    // Sign correction; a positive quotient with bit 15 set cannot be
    // represented (only 16'h8000 / 16'hFFFF reaches this)
    always_comb begin
        quotient_o  = fix_quo_neg_i ? neg16(quotient_mag_i)  : quotient_mag_i;
        remainder_o = fix_rem_neg_i ? neg16(remainder_mag_i) : remainder_mag_i;
        ovf_o       = ~fix_quo_neg_i & quotient_mag_i[15];
    end

endmodule

// File: rtl/alu_div_sequencer.sv
// Restoring divider that borrows the shared ALU for one subtract per cycle.
// Build macro ALU_DIV_SIGNED_EN adds signed division (magnitude conversion
// at accept plus a one-cycle FIXUP state); without it all divisions are
// unsigned and req_signed is ignored.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// RUN   | one quotient bit per cycle, ALU granted
// FIXUP | signed correction of quotient/remainder (ALU_DIV_SIGNED_EN only)
// DONE  | result held on resp_*, waiting for resp_ready
module alu_div_sequencer
    import alu_div_sequencer_pkg::*;
#(
    parameter logic [15:0] DIV0_QUOTIENT              = 16'hFFFF,
    parameter bit          DIV0_REMAINDER_IS_DIVIDEND = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_dividend,
    input  logic [15:0] req_divisor,
    input  logic        req_signed,
    input  logic [15:0] flags_in,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_quotient,
    output logic [15:0] resp_remainder,
    output logic [15:0] resp_flags,
    output logic        alu_grant,
    output logic [3:0]  alu_op_code,
    output logic [15:0] alu_source,
    output logic [15:0] alu_destination,
    input  logic [15:0] alu_result,
    input  logic [15:0] alu_flags
);

    div_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] dvd_q, dvd_d;
    logic [15:0] dsr_q, dsr_d;
    logic [15:0] quo_q, quo_d;
    logic [16:0] rem_q, rem_d;
    logic        div_err_q, div_err_d;
    logic        ovf_q, ovf_d;
    logic        grant;
    logic        success;
    logic [16:0] shifted;
    logic [15:0] dvd_in, dsr_in;
    logic        unused_bits;

`ifdef ALU_DIV_SIGNED_EN
    logic        sgn_q, sgn_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        acc_qneg, acc_rneg;
    logic [15:0] fix_quo, fix_rem;
    logic        fix_ovf;

    alu_div_sign_fix u_sign_fix (
        .signed_i        (req_signed),
        .dividend_i      (req_dividend),
        .divisor_i       (req_divisor),
        .dividend_mag_o  (dvd_in),
        .divisor_mag_o   (dsr_in),
        .quo_neg_o       (acc_qneg),
        .rem_neg_o       (acc_rneg),
        .fix_quo_neg_i   (qneg_q),
        .fix_rem_neg_i   (rneg_q),
        .quotient_mag_i  (quo_q),
        .remainder_mag_i (rem_q[15:0]),
        .quotient_o      (fix_quo),
        .remainder_o     (fix_rem),
        .ovf_o           (fix_ovf)
    );

    assign unused_bits = ^{flags_in[4:0], alu_flags[15:3], alu_flags[1:0], rem_q[16]};
`else
    assign dvd_in      = req_dividend;
    assign dsr_in      = req_divisor;
    assign unused_bits = ^{flags_in[4:0], alu_flags[15:3], alu_flags[1:0], rem_q[16], req_signed};
`endif

    // ALU operands come only from registers, so no path from alu_flags back
    // into alu_destination exists
    assign grant   = (state_q == RUN);
    assign shifted = {rem_q[15:0], dvd_q[cnt_q]};
    // A set shifted[16] means the partial remainder already exceeds any
    // 16-bit divisor, whatever borrow the ALU reports
    assign success = shifted[16] | ~alu_flags[FLAG_CARRY];

    // State register and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            div_err_q <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef ALU_DIV_SIGNED_EN
            sgn_q     <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            div_err_q <= div_err_d;
            ovf_q     <= ovf_d;
`ifdef ALU_DIV_SIGNED_EN
            sgn_q     <= sgn_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        div_err_d = div_err_q;
        ovf_d     = ovf_q;
        req_ready = 1'b0;
`ifdef ALU_DIV_SIGNED_EN
        sgn_d     = sgn_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
`endif
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    ovf_d = 1'b0;
                    if (req_divisor == 16'd0) begin
                        quo_d     = DIV0_QUOTIENT;
                        rem_d     = DIV0_REMAINDER_IS_DIVIDEND ? {1'b0, req_dividend} : 17'd0;
                        div_err_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        dvd_d     = dvd_in;
                        dsr_d     = dsr_in;
                        cnt_d     = 4'd15;
                        rem_d     = 17'd0;
                        quo_d     = 16'd0;
                        div_err_d = 1'b0;
                        state_d   = RUN;
                    end
`ifdef ALU_DIV_SIGNED_EN
                    sgn_d  = req_signed;
                    qneg_d = acc_qneg;
                    rneg_d = acc_rneg;
`endif
                end
            end
            RUN: begin
                rem_d = success ? {1'b0, alu_result} : shifted;
                quo_d = {quo_q[14:0], success};
                if (cnt_q == 4'd0) begin
`ifdef ALU_DIV_SIGNED_EN
                    state_d = sgn_q ? FIXUP : DONE;
`else
                    state_d = DONE;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            FIXUP: begin
`ifdef ALU_DIV_SIGNED_EN
                quo_d = fix_quo;
                rem_d = {1'b0, fix_rem};
                ovf_d = fix_ovf;
`endif
                state_d = DONE;
            end
            DONE: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_valid      = (state_q == DONE);
    assign resp_quotient   = quo_q;
    assign resp_remainder  = rem_q[15:0];
    assign alu_grant       = grant;
    assign alu_op_code     = grant ? ALU_OP_SUB : ALU_OP_COPY;
    assign alu_source      = grant ? dsr_q : 16'd0;
    assign alu_destination = grant ? shifted[15:0] : 16'd0;

    // Flags word is only meaningful while a result is presented
    always_comb begin
        resp_flags = 16'd0;
        if (state_q == DONE) begin
            resp_flags[15:5]         = flags_in[15:5];
            resp_flags[FLAG_DIV_ERR] = div_err_q;
            resp_flags[FLAG_OVF]     = ovf_q;
            resp_flags[FLAG_NEG]     = quo_q[15];
            resp_flags[FLAG_ZERO]    = (quo_q == 16'd0);
        end
    end

endmodule

// File: tb/tb_alu_div_sequencer.sv
module tb_alu_div_sequencer;

`ifdef ALU_DIV_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif
    localparam logic [15:0] FLAGS_FIXED = 16'hABCD;

    logic        clock, reset;
    logic        req_valid, req_ready, req_signed;
    logic [15:0] req_dividend, req_divisor, flags_in;
    logic        resp_valid, resp_ready;
    logic [15:0] resp_quotient, resp_remainder, resp_flags;
    logic        alu_grant;
    logic [3:0]  alu_op_code;
    logic [15:0] alu_source, alu_destination, alu_result, alu_flags;

    int n_assert = 0;
    int n_fail   = 0;

    alu_div_sequencer dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_dividend    (req_dividend),
        .req_divisor     (req_divisor),
        .req_signed      (req_signed),
        .flags_in        (flags_in),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_quotient   (resp_quotient),
        .resp_remainder  (resp_remainder),
        .resp_flags      (resp_flags),
        .alu_grant       (alu_grant),
        .alu_op_code     (alu_op_code),
        .alu_source      (alu_source),
        .alu_destination (alu_destination),
        .alu_result      (alu_result),
        .alu_flags       (alu_flags)
    );

    // Shared ALU stand-in: subtract with borrow on flag bit 2
    assign alu_result = alu_destination - alu_source;
    assign alu_flags  = {13'd0, (alu_destination < alu_source), 2'd0};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        bit          s;
        logic [15:0] q;
        logic [15:0] r;
        bit          ovf;
        bit          derr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_flags(input logic [15:0] fin, input logic [15:0] q,
                                              input bit derr, input bit ovf);
        return {fin[15:5], derr, ovf, 1'b0, q[15], (q == 16'd0)};
    endfunction

    // Behavioural reference: plain integer division
    function automatic void ref_div(input logic [15:0] a, input logic [15:0] b, input bit s,
                                    output logic [15:0] q, output logic [15:0] r,
                                    output bit ovf, output bit derr);
        int sa, sb, qi, ri;
        ovf  = 1'b0;
        derr = 1'b0;
        if (b == 16'd0) begin
            q    = 16'hFFFF;
            r    = a;
            derr = 1'b1;
        end else if (s && SIGNED_BUILD) begin
            sa  = int'($signed(a));
            sb  = int'($signed(b));
            qi  = sa / sb;
            ri  = sa % sb;
            q   = qi[15:0];
            r   = ri[15:0];
            ovf = (qi > 32767) || (qi < -32768);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // One full request/response; called at a negedge, returns at a negedge
    task automatic do_div(input logic [15:0] a, input logic [15:0] b, input bit s,
                          output logic [15:0] q, output logic [15:0] r, output logic [15:0] f,
                          output int lat, output int gcnt, output bit op_ok);
        int waitc = 0;
        while (!req_ready && waitc < 50) begin
            @(negedge clock);
            waitc++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_dividend = a;
        req_divisor  = b;
        req_signed   = s;
        @(negedge clock);
        req_valid = 1'b0;
        lat   = 1;
        gcnt  = 0;
        op_ok = 1'b1;
        while (!resp_valid && lat < 100) begin
            if (alu_grant) begin
                gcnt++;
                if (alu_op_code !== 4'hB) op_ok = 1'b0;
            end else if (alu_op_code !== 4'h0) begin
                op_ok = 1'b0;
            end
            @(negedge clock);
            lat++;
        end
        q = resp_quotient;
        r = resp_remainder;
        f = resp_flags;
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] q, r, f, eq, er;
        int          lat, gcnt, cnt;
        bit          op_ok, eovf, ederr, s;
        logic [15:0] a, b;

        reset        = 1'b1;
        req_valid    = 1'b0;
        req_dividend = 16'd0;
        req_divisor  = 16'd0;
        req_signed   = 1'b0;
        resp_ready   = 1'b0;
        flags_in     = FLAGS_FIXED;

        vecs.push_back('{16'd100,  16'd7,     1'b0, 16'd14,   16'd2,    1'b0, 1'b0});
        vecs.push_back('{16'hFFFF, 16'd1,     1'b0, 16'hFFFF, 16'd0,    1'b0, 1'b0});
        vecs.push_back('{16'hFFFF, 16'hFFFF,  1'b0, 16'd1,    16'd0,    1'b0, 1'b0});
        vecs.push_back('{16'h8000, 16'h8001,  1'b0, 16'd0,    16'h8000, 1'b0, 1'b0});
        vecs.push_back('{16'd1234, 16'd0,     1'b0, 16'hFFFF, 16'd1234, 1'b0, 1'b1});
        vecs.push_back('{16'hFFF9, 16'd2,     1'b0, 16'h7FFC, 16'd1,    1'b0, 1'b0});
        if (SIGNED_BUILD) begin
            vecs.push_back('{16'hFFF9, 16'd2,    1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0});
            vecs.push_back('{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'd0,    1'b1, 1'b0});
            vecs.push_back('{16'd7,    16'hFFFE, 1'b1, 16'hFFFD, 16'd1,    1'b0, 1'b0});
        end else begin
            vecs.push_back('{16'hFFF9, 16'd2,    1'b1, 16'h7FFC, 16'd1,    1'b0, 1'b0});
            vecs.push_back('{16'h8000, 16'hFFFF, 1'b1, 16'd0,    16'h8000, 1'b0, 1'b0});
        end

        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Reset state
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_quotient", 32'(resp_quotient), 32'd0);
        check("rst_remainder", 32'(resp_remainder), 32'd0);
        check("rst_flags", 32'(resp_flags), 32'd0);
        check("rst_grant", 32'(alu_grant), 32'd0);
        check("rst_op", 32'(alu_op_code), 32'd0);
        check("rst_src", 32'(alu_source), 32'd0);
        check("rst_dst", 32'(alu_destination), 32'd0);

        // Directed table
        foreach (vecs[i]) begin
            do_div(vecs[i].a, vecs[i].b, vecs[i].s, q, r, f, lat, gcnt, op_ok);
            check($sformatf("vec%0d_quotient", i), 32'(q), 32'(vecs[i].q));
            check($sformatf("vec%0d_remainder", i), 32'(r), 32'(vecs[i].r));
            check($sformatf("vec%0d_flags", i), 32'(f),
                  32'(exp_flags(FLAGS_FIXED, vecs[i].q, vecs[i].derr, vecs[i].ovf)));
            check($sformatf("vec%0d_latency", i), 32'(lat),
                  vecs[i].derr ? 32'd1 : ((vecs[i].s && SIGNED_BUILD) ? 32'd18 : 32'd17));
            check($sformatf("vec%0d_grant_cycles", i), 32'(gcnt), vecs[i].derr ? 32'd0 : 32'd16);
            check($sformatf("vec%0d_opcode", i), 32'(op_ok), 32'd1);
        end

        // Hold in DONE with a competing request, then back-to-back accept
        do_div(16'd0, 16'd1, 1'b0, q, r, f, lat, gcnt, op_ok);
        req_valid = 1'b1; req_dividend = 16'd100; req_divisor = 16'd7; req_signed = 1'b0;
        @(negedge clock);
        req_valid = 1'b0;
        cnt = 0;
        while (!resp_valid && cnt < 40) begin @(negedge clock); cnt++; end
        req_valid = 1'b1; req_dividend = 16'd500; req_divisor = 16'd9;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_ready", 32'(req_ready), 32'd0);
            check("hold_quotient", 32'(resp_quotient), 32'd14);
            check("hold_remainder", 32'(resp_remainder), 32'd2);
            check("hold_flags", 32'(resp_flags), 32'(exp_flags(FLAGS_FIXED, 16'd14, 1'b0, 1'b0)));
        end
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        check("b2b_ready_after_hs", 32'(req_ready), 32'd1);
        check("b2b_valid_after_hs", 32'(resp_valid), 32'd0);
        @(negedge clock);
        req_valid = 1'b0;
        cnt = 0;
        while (!resp_valid && cnt < 40) begin @(negedge clock); cnt++; end
        check("b2b_quotient", 32'(resp_quotient), 32'd55);
        check("b2b_remainder", 32'(resp_remainder), 32'd5);
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;

        // Reset during RUN iteration 8
        req_valid = 1'b1; req_dividend = 16'd40000; req_divisor = 16'd3;
        @(negedge clock);
        req_valid = 1'b0;
        cnt = 0;
        lat = 0;
        while (cnt < 8 && lat < 40) begin
            if (alu_grant) cnt++;
            if (cnt < 8) @(negedge clock);
            lat++;
        end
        check("abort_reached_iter8", 32'(cnt), 32'd8);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_grant", 32'(alu_grant), 32'd0);
        check("abort_op", 32'(alu_op_code), 32'd0);
        check("abort_quotient", 32'(resp_quotient), 32'd0);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (resp_valid) cnt++;
            @(negedge clock);
        end
        check("abort_no_response", 32'(cnt), 32'd0);

        // Randomized against the reference model
        for (int i = 0; i < 60; i++) begin
            a = 16'($urandom_range(0, 65535));
            case ($urandom_range(0, 9))
                0:       b = 16'd0;
                1:       b = 16'd1;
                2:       b = 16'hFFFF;
                3, 4, 5: b = 16'($urandom_range(1, 15));
                default: b = 16'($urandom_range(0, 65535));
            endcase
            if (i == 7) begin a = 16'h8000; b = 16'hFFFF; end
            s        = 1'($urandom_range(0, 1));
            flags_in = 16'($urandom_range(0, 65535));
            ref_div(a, b, s, eq, er, eovf, ederr);
            do_div(a, b, s, q, r, f, lat, gcnt, op_ok);
            check($sformatf("rnd%0d_quotient %h/%h s%0d", i, a, b, s), 32'(q), 32'(eq));
            check($sformatf("rnd%0d_remainder", i), 32'(r), 32'(er));
            check($sformatf("rnd%0d_flags", i), 32'(f), 32'(exp_flags(flags_in, eq, ederr, eovf)));
            check($sformatf("rnd%0d_latency", i), 32'(lat),
                  ederr ? 32'd1 : ((s && SIGNED_BUILD) ? 32'd18 : 32'd17));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
